// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with KMP fallback and optional overlap.
// Define SEQ_DET_COUNT_EN to compile in the saturating match_cnt port and counter.
module seq_detect_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           OVERLAP = 1,
    parameter int           CNT_W   = 8,
    localparam int          SW      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             x_in,
    output logic             y_out,
`ifdef SEQ_DET_COUNT_EN
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
`else
    output logic [SW-1:0]    state
`endif
);

    localparam logic [SW-1:0] LAST = SW'(N - 1);

    if ((N < 2) || (N > 8) || (CNT_W < 2) || (CNT_W > 16)) begin : g_bad_cfg
        $error("seq_detect_param: N or CNT_W outside supported range");
    end

    // Bit p of the stream "first k PATTERN bits followed by b" (p = 0 is oldest).
    function automatic logic ext_bit(input int p, input int k, input logic b);
        logic r;
        if (p < k) begin
            r = PATTERN[N - 1 - p];
        end else begin
            r = b;
        end
        return r;
    endfunction

    // Next prefix length after receiving b in prefix state k: longest PATTERN
    // prefix (shorter than N) that is a suffix of the extended stream.
    function automatic int kmp_next(input int k, input logic b);
        int   best;
        logic ok;
        best = 32'sd0;
        if ((k == N - 1) && (b == PATTERN[0]) && (OVERLAP == 32'sd0)) begin
            best = 32'sd0;
        end else begin
            for (int l = 32'sd1; l <= k + 32'sd1; l++) begin
                if (l <= N - 1) begin
                    ok = 1'b1;
                    for (int j = 32'sd0; j < l; j++) begin
                        if (ext_bit(k + 32'sd1 - l + j, k, b) != PATTERN[N - 1 - j]) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = l;
                    end
                end
            end
        end
        return best;
    endfunction

    logic [SW-1:0] nxt0_s [N];
    logic [SW-1:0] nxt1_s [N];
    logic [SW-1:0] state_nxt_s;
    logic          match_s;
    logic [SW-1:0] state_r;
    logic          y_r;

    for (genvar k = 0; k < N; k++) begin : g_tbl
        assign nxt0_s[k] = SW'(kmp_next(k, 1'b0));
        assign nxt1_s[k] = SW'(kmp_next(k, 1'b1));
    end

    // Transition lookup and match decode for the current input bit
    always_comb begin
        state_nxt_s = state_r;
        match_s     = 1'b0;
        if (x_in) begin
            state_nxt_s = nxt1_s[state_r];
        end else begin
            state_nxt_s = nxt0_s[state_r];
        end
        if ((state_r == LAST) && (x_in == PATTERN[0])) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // FSM state and match pulse, priority rst > clr > en
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= '0;
            y_r     <= 1'b0;
        end else if (clr) begin
            state_r <= '0;
            y_r     <= 1'b0;
        end else if (en) begin
            state_r <= state_nxt_s;
            y_r     <= match_s;
        end else begin
            state_r <= state_r;
            y_r     <= 1'b0;
        end
    end

    assign state = state_r;
    assign y_out = y_r;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating match counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && match_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign match_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: four configurations driven by one
// stimulus stream, checked every cycle against a history-based stream model.
module tb_seq_detect_param;

    localparam int NUM = 4;
    localparam int PN   [NUM] = '{4, 4, 4, 3};
    localparam int PPAT [NUM] = '{11, 11, 11, 6};
    localparam int POVL [NUM] = '{1, 0, 0, 1};
    localparam int PCW  [NUM] = '{8, 8, 2, 8};

    logic clk = 1'b0;
    logic rst, clr, en, x_in;
    logic       y_w  [NUM];
    logic [1:0] st_w [NUM];
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] cnt0_w, cnt1_w, cnt3_w;
    logic [1:0] cnt2_w;
    logic [7:0] cnt_w [NUM];
    assign cnt_w[0] = cnt0_w;
    assign cnt_w[1] = cnt1_w;
    assign cnt_w[2] = {6'd0, cnt2_w};
    assign cnt_w[3] = cnt3_w;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x_in(x_in),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt0_w),
`endif
        .y_out(y_w[0]), .state(st_w[0]));

    seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x_in(x_in),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt1_w),
`endif
        .y_out(y_w[1]), .state(st_w[1]));

    seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x_in(x_in),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt2_w),
`endif
        .y_out(y_w[2]), .state(st_w[2]));

    seq_detect_param #(.N(3), .PATTERN(3'b110), .OVERLAP(1), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x_in(x_in),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt3_w),
`endif
        .y_out(y_w[3]), .state(st_w[3]));

    // Stream model: history of accepted bits since stream start (newest in bit 0)
    logic [31:0] hist [NUM];
    int          hlen [NUM];
    int          ey   [NUM];
    int          es   [NUM];
    int          ecnt [NUM];

    function automatic bit tail_is_prefix(input int i, input logic [31:0] h, input int hl, input int l);
        logic [31:0] mask;
        mask = (32'd1 << l) - 32'd1;
        return (hl >= l) && ((h & mask) == 32'(PPAT[i] >> (PN[i] - l)));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (rst || clr) begin
                hist[i] = '0; hlen[i] = 0; ey[i] = 0; ecnt[i] = 0;
            end else if (en) begin
                hist[i] = {hist[i][30:0], x_in};
                if (hlen[i] < 31) hlen[i]++;
                ey[i] = tail_is_prefix(i, hist[i], hlen[i], PN[i]) ? 1 : 0;
                if (ey[i] == 1) begin
                    if (ecnt[i] < (1 << PCW[i]) - 1) ecnt[i]++;
                    if (POVL[i] == 0) begin
                        hist[i] = '0; hlen[i] = 0;
                    end
                end
            end else begin
                ey[i] = 0;
            end
            es[i] = 0;
            for (int l = 1; l < PN[i]; l++)
                if (tail_is_prefix(i, hist[i], hlen[i], l)) es[i] = l;
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, expv);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NUM; i++) begin
                chk("y_out", i, 32'(y_w[i]), 32'(ey[i]));
                chk("state", i, 32'(st_w[i]), 32'(es[i]));
`ifdef SEQ_DET_COUNT_EN
                chk("match_cnt", i, 32'(cnt_w[i]), 32'(ecnt[i]));
`endif
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic e, input logic x);
        rst = r; clr = c; en = e; x_in = x;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ov_bits = 7'b1011011;
    logic [5:0] fb_bits = 6'b101011;
    int         fb_st [5] = '{1, 2, 3, 2, 3};
    logic       tog = 1'b0;

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b1; x_in = 1'b0;

        // Reset with random data present
        step(1'b1, 1'b0, 1'b1, 1'($urandom));
        step(1'b1, 1'b0, 1'b1, 1'($urandom));
        chk_en = 1'b1;
        chk("rst_state", 0, 32'(st_w[0]), 32'd0);
        chk("rst_y", 0, 32'(y_w[0]), 32'd0);
`ifdef SEQ_DET_COUNT_EN
        chk("rst_cnt", 0, 32'(cnt0_w), 32'd0);
`endif

        // Overlap / non-overlap stream 1,0,1,1,0,1,1
        for (int b = 0; b < 7; b++) begin
            step(1'b0, 1'b0, 1'b1, ov_bits[6-b]);
            if (b == 3) begin
                chk("ovl_y_bit4", 0, 32'(y_w[0]), 32'd1);
                chk("ovl_state_bit4", 0, 32'(st_w[0]), 32'd1);
                chk("novl_y_bit4", 1, 32'(y_w[1]), 32'd1);
                chk("novl_state_bit4", 1, 32'(st_w[1]), 32'd0);
            end
        end
        chk("ovl_y_bit7", 0, 32'(y_w[0]), 32'd1);
        chk("novl_y_bit7", 1, 32'(y_w[1]), 32'd0);
        chk("novl_state_final", 1, 32'(st_w[1]), 32'd1);
`ifdef SEQ_DET_COUNT_EN
        chk("ovl_cnt", 0, 32'(cnt0_w), 32'd2);
        chk("novl_cnt", 1, 32'(cnt1_w), 32'd1);
`endif

        // KMP fallback stream 1,0,1,0,1,1
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            step(1'b0, 1'b0, 1'b1, fb_bits[5-b]);
            if (b < 5) chk("fallback_state", b, 32'(st_w[0]), 32'(fb_st[b]));
        end
        chk("fallback_y_bit6", 0, 32'(y_w[0]), 32'd1);

        // Enable gaps with x_in toggling
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 7; b++) begin
            step(1'b0, 1'b0, 1'b1, ov_bits[6-b]);
            if (b == 3 || b == 6) chk("gap_y_pulse", b, 32'(y_w[0]), 32'd1);
            for (int g = 0; g < 3; g++) begin
                tog = ~tog;
                step(1'b0, 1'b0, 1'b0, tog);
                if (g == 0) chk("gap_y_low", b, 32'(y_w[0]), 32'd0);
            end
        end

        // Clear after bit 3 discards the bit presented with it
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_state", 0, 32'(st_w[0]), 32'd0);
        chk("clr_y", 0, 32'(y_w[0]), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_bit4_y", 0, 32'(y_w[0]), 32'd0);
        chk("clr_bit4_state", 0, 32'(st_w[0]), 32'd1);

        // Saturation: five non-overlapping matches on a 2-bit counter
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 5; m++)
            for (int b = 0; b < 4; b++)
                step(1'b0, 1'b0, 1'b1, ov_bits[6-b]);
`ifdef SEQ_DET_COUNT_EN
        chk("sat_cnt", 2, 32'(cnt2_w), 32'd3);
        chk("sat_cnt_wide", 1, 32'(cnt1_w), 32'd5);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_DET_COUNT_EN
        chk("sat_cnt_hold", 2, 32'(cnt2_w), 32'd3);
`endif
        step(1'b0, 1'b1, 1'b1, 1'b1);
`ifdef SEQ_DET_COUNT_EN
        chk("sat_cnt_clr", 2, 32'(cnt2_w), 32'd0);
`endif

        // Mixed tail with occasional reset/clear and enable gaps
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(63) == 0), ($urandom_range(31) == 0),
                 ($urandom_range(3) != 0), 1'($urandom));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
